// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, operation codes and flag bit positions.
// Every block that drives or decodes the shared ALU imports this package.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101
    } alu_op_e;

    // Bit positions inside alu_flags / rsp_flags
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef struct packed {
        logic              port;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter with a last-grant pointer; round-robin or fixed port-0 priority.
// Grants are purely combinational; the pointer only moves on an accepted transfer.
module rr_arbiter2
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       kill_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        if (rst_ni && !kill_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Contention: port 0 wins unless it was the one served last
                2'b11:   gnt_o = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        last_d = (gnt_o != 2'b00) ? gnt_o[1] : last_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters through a two-stage pipeline:
// stage 1 holds the granted operands driving the ALU, stage 2 registers the ALU result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              busy
);

    logic [1:0]        gnt;
    alu_req_t          req_sel;
    alu_req_t          req_p1_q;
    logic              vld_p1_q;
    logic              vld_p2_q;
    logic              port_p2_q;
    logic [DATA_W-1:0] result_p2_q;
    logic [FLAG_W-1:0] flags_p2_q;

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req_valid),
        .kill_i(flush),
        .gnt_o (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        req_sel.port = gnt[1];
        req_sel.op   = gnt[1] ? req1_op : req0_op;
        req_sel.a    = gnt[1] ? req1_a  : req0_a;
        req_sel.b    = gnt[1] ? req1_b  : req0_b;
    end

    // Stage 1: accepted request, drives the shared ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= (|gnt) && !flush;
        end
    end

    always_ff @(posedge clk) begin
        if (|gnt) begin
            req_p1_q <= req_sel;
        end
    end

    assign alu_a       = vld_p1_q ? req_p1_q.a  : '0;
    assign alu_b       = vld_p1_q ? req_p1_q.b  : '0;
    assign alu_control = vld_p1_q ? req_p1_q.op : '0;

    // Stage 2: registered ALU output; payload only moves on a live op so it holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
            flags_p2_q  <= '0;
        end else begin
            vld_p2_q <= vld_p1_q && !flush;
            if (vld_p1_q && !flush) begin
                result_p2_q <= alu_result;
                flags_p2_q  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            port_p2_q <= req_p1_q.port;
        end
    end

    assign rsp_valid  = vld_p2_q ? (port_p2_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_p2_q;
    assign rsp_flags  = flags_p2_q;
    assign busy       = vld_p1_q | vld_p2_q;

endmodule
